// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the scoreboard entry layout and the forward-select width helper.
package hazard_pkg;

    // Register fields are sized for the widest supported register file (8 bits).
    typedef struct packed {
        logic       valid;
        logic [7:0] rd;
        logic       wr;
        logic       load;
        logic [7:0] rs1;
        logic [7:0] rs2;
        logic       use1;
        logic       use2;
    } sb_entry_t;

    function automatic int fwd_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// Youngest-producer priority encoder over a scoreboard window.
// Reports the lowest stage index at or above FIRST that writes the source.
module sb_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int FIRST = 0,
    parameter int FW    = 2
) (
    input  logic [DEPTH-1:0]      valid_i,
    input  logic [DEPTH-1:0]      wr_i,
    input  logic [DEPTH-1:0]      load_i,
    input  logic [DEPTH-1:0][7:0] rd_i,
    input  logic [7:0]            src_i,
    input  logic                  use_i,
    output logic                  hit_o,
    output logic [FW-1:0]         idx_o,
    output logic                  load_o
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        load_o = 1'b0;
        for (int k = DEPTH - 1; k >= FIRST; k--) begin
            if (use_i && valid_i[k] && wr_i[k] && (rd_i[k] == src_i)) begin
                hit_o  = 1'b1;
                idx_o  = FW'(k);
                load_o = load_i[k];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forwarding control for an in-order pipeline.
// Tracks post-ID instructions in a shift-register scoreboard.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int RF_ADDRESS = 5,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [RF_ADDRESS-1:0]   id_rs1,
    input  logic [RF_ADDRESS-1:0]   id_rs2,
    input  logic [RF_ADDRESS-1:0]   id_rd,
    input  logic                    id_use1,
    input  logic                    id_use2,
    input  logic                    id_regwrite,
    input  logic                    id_is_load,
    input  logic                    ex_redirect,
    input  logic                    ex_busy,
    output logic                    stall_fetch,
    output logic                    stall_decode,
    output logic                    flush_decode,
    output logic                    bubble_ex,
    output logic [fwd_w(DEPTH)-1:0] fwd_sel_a,
    output logic [fwd_w(DEPTH)-1:0] fwd_sel_b,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    localparam int FW = fwd_w(DEPTH);

    sb_entry_t sb_q [DEPTH];
    sb_entry_t sb_d [DEPTH];
    sb_entry_t id_ent;

    logic [DEPTH-1:0]      v_vec;
    logic [DEPTH-1:0]      wr_vec;
    logic [DEPTH-1:0]      ld_vec;
    logic [DEPTH-1:0][7:0] rd_vec;

    logic          ih1, ih2, il1, il2;
    logic [FW-1:0] ii1, ii2;
    logic          eh1, eh2, el1, el2;
    logic [FW-1:0] ei1, ei2;

    logic load_use, busy, redir, lu;
    logic rdy_a, rdy_b;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic unused_tail;

    // Fields of the oldest entry that only matter while it is still shifting.
    assign unused_tail = ^{sb_q[DEPTH-1].rs1, sb_q[DEPTH-1].rs2,
                           sb_q[DEPTH-1].use1, sb_q[DEPTH-1].use2};

    // Pack the ID fields into a scoreboard entry; x0 is never a real write.
    always_comb begin
        id_ent       = '0;
        id_ent.valid = id_valid;
        id_ent.rd    = 8'(id_rd);
        id_ent.wr    = id_regwrite && (id_rd != '0);
        id_ent.load  = id_is_load;
        id_ent.rs1   = 8'(id_rs1);
        id_ent.rs2   = 8'(id_rs2);
        id_ent.use1  = id_use1;
        id_ent.use2  = id_use2;
    end

    // Flatten the producer fields for the match encoders.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            v_vec[k]  = sb_q[k].valid;
            wr_vec[k] = sb_q[k].wr;
            ld_vec[k] = sb_q[k].load;
            rd_vec[k] = sb_q[k].rd;
        end
    end

    sb_match #(.DEPTH(DEPTH), .FIRST(0), .FW(FW)) u_id1 (
        .valid_i(v_vec), .wr_i(wr_vec), .load_i(ld_vec), .rd_i(rd_vec),
        .src_i(8'(id_rs1)), .use_i(id_valid && id_use1),
        .hit_o(ih1), .idx_o(ii1), .load_o(il1)
    );

    sb_match #(.DEPTH(DEPTH), .FIRST(0), .FW(FW)) u_id2 (
        .valid_i(v_vec), .wr_i(wr_vec), .load_i(ld_vec), .rd_i(rd_vec),
        .src_i(8'(id_rs2)), .use_i(id_valid && id_use2),
        .hit_o(ih2), .idx_o(ii2), .load_o(il2)
    );

    sb_match #(.DEPTH(DEPTH), .FIRST(1), .FW(FW)) u_ex1 (
        .valid_i(v_vec), .wr_i(wr_vec), .load_i(ld_vec), .rd_i(rd_vec),
        .src_i(sb_q[0].rs1), .use_i(sb_q[0].valid && sb_q[0].use1),
        .hit_o(eh1), .idx_o(ei1), .load_o(el1)
    );

    sb_match #(.DEPTH(DEPTH), .FIRST(1), .FW(FW)) u_ex2 (
        .valid_i(v_vec), .wr_i(wr_vec), .load_i(ld_vec), .rd_i(rd_vec),
        .src_i(sb_q[0].rs2), .use_i(sb_q[0].valid && sb_q[0].use2),
        .hit_o(eh2), .idx_o(ei2), .load_o(el2)
    );

    // Hazard resolution: busy beats redirect beats load-use; reset masks all.
    always_comb begin
        load_use = (ih1 && il1 && (int'(ii1) < LOAD_STAGE - 1)) ||
                   (ih2 && il2 && (int'(ii2) < LOAD_STAGE - 1));
        busy  = ex_busy;
        redir = ex_redirect && !ex_busy;
        lu    = load_use && !busy && !redir;
        rdy_a = eh1 && (!el1 || (int'(ei1) >= LOAD_STAGE));
        rdy_b = eh2 && (!el2 || (int'(ei2) >= LOAD_STAGE));
        stall_fetch  = !reset && (busy || lu);
        stall_decode = !reset && (busy || lu);
        flush_decode = !reset && redir;
        bubble_ex    = !reset && (redir || lu);
        fwd_sel_a    = (!reset && rdy_a) ? ei1 : '0;
        fwd_sel_b    = (!reset && rdy_b) ? ei2 : '0;
    end

    // Scoreboard next state: shift by default, hold EX on busy, bubble on hazard.
    always_comb begin
        sb_d[0] = id_ent;
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        if (busy) begin
            sb_d[0] = sb_q[0];
            sb_d[1] = '0;
        end else if (redir || lu) begin
            sb_d[0] = '0;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fetch && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_decode && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= sb_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
